// File: rtl/inst_fetch_pkg.sv
// ------------------------------------------------------------------
// inst_fetch_pkg : shared ISA field codes, width defaults, fetch FSM states
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package inst_fetch_pkg;

  localparam int AW_DEF = 16;
  localparam int IW_DEF = 16;

  localparam logic [4:0] OP_ALU  = 5'h00;
  localparam logic [4:0] OP_ADDI = 5'h01;
  localparam logic [4:0] OP_LW   = 5'h02;
  localparam logic [4:0] OP_SW   = 5'h03;
  localparam logic [4:0] OP_BEQ  = 5'h04;
  localparam logic [4:0] OP_BNE  = 5'h05;
  localparam logic [4:0] OP_J    = 5'h06;
  localparam logic [4:0] OP_JAL  = 5'h07;

  localparam logic [4:0] F_ADD  = 5'h00;
  localparam logic [4:0] F_SUB  = 5'h01;
  localparam logic [4:0] F_AND  = 5'h02;
  localparam logic [4:0] F_OR   = 5'h03;
  localparam logic [4:0] F_JR   = 5'h08;
  localparam logic [4:0] F_JALR = 5'h09;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } if_state_e;

  function automatic logic [4:0] inst_opcode(input logic [IW_DEF-1:0] inst);
    return inst[IW_DEF-1 -: 5];
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ------------------------------------------------------------------
// fetch_queue : synchronous FIFO with flush, first-word-fall-through head
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int         PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != FULL) || do_pop);
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/inst_fetch.sv
// ------------------------------------------------------------------
// inst_fetch : PC owner, in-order imem reads, prefetch queue, redirect squash.
// Optional IF_PERF_CNT_EN adds perf_bubble_o / perf_squash_o.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            IW       = IW_DEF,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic          imem_rvalid_i,
  input  logic [IW-1:0] imem_rdata_i,
  input  logic          redir_valid_i,
  input  logic [AW-1:0] redir_pc_i,
  input  logic          halt_i,
  output logic          if_valid_o,
  input  logic          if_ready_i,
  output logic [IW-1:0] if_inst_o,
  output logic [AW-1:0] if_pc_o,
  output logic [AW-1:0] if_pc_inc_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]   perf_bubble_o,
  output logic [31:0]   perf_squash_o
`endif
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  if_state_e        state_q;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    in_flight_q, in_flight_d;
  logic [CW-1:0]    drop_q, drop_d;
  logic [CW-1:0]    q_count;
  logic [CW-1:0]    tag_count;
  logic [AW-1:0]    tag_head;
  logic [IW+AW-1:0] q_head;
  logic             credit_ok;
  logic             issue;
  logic             rsp_ok;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             pop;

  // in_flight counts every outstanding read, including ones already marked for drop.
  always_comb begin
    credit_ok   = ({1'b0, in_flight_q} + {1'b0, q_count}) < CREDITS;
    imem_req_o  = (state_q != S_IDLE) && !halt_i && !redir_valid_i && credit_ok;
    issue       = imem_req_o && imem_ack_i;
    rsp_ok      = imem_rvalid_i && (in_flight_q != '0);
    rsp_drop    = rsp_ok && (drop_q != '0);
    rsp_keep    = rsp_ok && (drop_q == '0) && (tag_count != '0);
    pop         = if_valid_o && if_ready_i;
    in_flight_d = in_flight_q + CW'(issue) - CW'(rsp_ok);
    drop_d      = redir_valid_i ? in_flight_d : (drop_q - CW'(rsp_drop));
    if (redir_valid_i) begin
      fetch_pc_d = redir_pc_i;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      in_flight_q <= '0;
      drop_q      <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      case (state_q)
        S_IDLE:  state_q <= S_RUN;
        S_RUN:   if (redir_valid_i && (drop_d != '0)) state_q <= S_DRAIN;
        S_DRAIN: if (!redir_valid_i && (drop_d == '0)) state_q <= S_RUN;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fetch_queue #(.W(AW), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redir_valid_i),
    .push_i  (issue),
    .wdata_i (fetch_pc_q),
    .pop_i   (rsp_keep),
    .rdata_o (tag_head),
    .count_o (tag_count)
  );

  fetch_queue #(.W(IW + AW), .DEPTH(DEPTH)) u_data_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redir_valid_i),
    .push_i  (rsp_keep),
    .wdata_i ({imem_rdata_i, tag_head}),
    .pop_i   (pop),
    .rdata_o (q_head),
    .count_o (q_count)
  );

  assign imem_addr_o = fetch_pc_q;
  assign if_valid_o  = (q_count != '0);
  assign if_inst_o   = q_head[IW+AW-1:AW];
  assign if_pc_o     = q_head[AW-1:0];
  assign if_pc_inc_o = if_pc_o + 1'b1;

`ifdef IF_PERF_CNT_EN
  logic [31:0]   bubble_q;
  logic [31:0]   squash_q;
  logic [CW-1:0] squashed;
  logic [32:0]   squash_sum;

  // A pop on the redirect cycle was accepted by decode, so it is not a squash.
  always_comb begin
    squashed   = (redir_valid_i ? (q_count - CW'(pop)) : '0)
               + CW'(rsp_ok && (redir_valid_i || (drop_q != '0)));
    squash_sum = {1'b0, squash_q} + 33'(squashed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
      squash_q <= '0;
    end else begin
      if (if_ready_i && !if_valid_o && (bubble_q != '1)) begin
        bubble_q <= bubble_q + 1'b1;
      end
      squash_q <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end

  assign perf_bubble_o = bubble_q;
  assign perf_squash_o = squash_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ------------------------------------------------------------------
// tb_inst_fetch : randomized self-checking bench for inst_fetch
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_inst_fetch;

  localparam int            AW       = 16;
  localparam int            IW       = 16;
  localparam int            DEPTH    = 4;
  localparam logic [AW-1:0] RESET_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          redir_valid = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  logic          halt = 1'b0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [IW-1:0] if_inst;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_pc_inc;

  always #5 clk = ~clk;

  inst_fetch #(
    .AW(AW), .IW(IW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redir_valid_i (redir_valid),
    .redir_pc_i    (redir_pc),
    .halt_i        (halt),
    .if_valid_o    (if_valid),
    .if_ready_i    (if_ready),
    .if_inst_o     (if_inst),
    .if_pc_o       (if_pc),
    .if_pc_inc_o   (if_pc_inc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hA5C3;
  endfunction

  // Memory model: in-order responses, each due a random latency after acceptance.
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rsp_t;
  rsp_t mem_q[$];

  int            cyc = 0;
  int            last_due = 0;
  int            lat_min = 1, lat_max = 1;
  int            ack_pct = 100, rdy_pct = 100;
  bit            rst_v = 1'b1;
  bit            halt_v = 1'b0;
  bit            redir_req = 1'b0;
  bit            redir_on_pp = 1'b0;
  bit            redir_prev = 1'b0;
  logic [AW-1:0] redir_tgt = '0;
  logic [AW-1:0] exp_pc = RESET_PC;
  logic [AW-1:0] exp_fetch = RESET_PC;
  int            acks = 0, pops = 0;

  // One clock: drive at negedge, sample and score at negedge+1.
  task automatic step();
    rsp_t r;
    int   lat;
    bit   do_redir;
    @(negedge clk);
    rst         = rst_v;
    imem_rvalid = 1'b0;
    imem_rdata  = IW'($urandom);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r           = mem_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(r.addr);
    end
    imem_ack = ($urandom_range(99) < ack_pct);
    if_ready = ($urandom_range(99) < rdy_pct);
    halt     = halt_v;
    do_redir = redir_req;
    if (redir_on_pp && imem_rvalid && if_valid && if_ready) do_redir = 1'b1;
    if (do_redir) begin
      redir_req   = 1'b0;
      redir_on_pp = 1'b0;
    end
    redir_valid = do_redir;
    redir_pc    = redir_tgt;
    #1;
    if (!rst) begin
      if (redir_prev) check_eq("valid_after_redir", 32'(if_valid), 32'd0);
      if (halt || redir_valid) check_eq("req_blocked", 32'(imem_req), 32'd0);
      if (imem_req && imem_ack) begin
        check_eq("fetch_addr", 32'(imem_addr), 32'(exp_fetch));
        lat    = $urandom_range(lat_max, lat_min);
        r.addr = imem_addr;
        r.due  = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        mem_q.push_back(r);
        exp_fetch = exp_fetch + 1'b1;
        acks++;
      end
      if (if_valid && if_ready) begin
        check_eq("if_pc", 32'(if_pc), 32'(exp_pc));
        check_eq("if_inst", 32'(if_inst), 32'(mem_word(exp_pc)));
        check_eq("if_pc_inc", 32'(if_pc_inc), 32'(AW'(exp_pc + 1'b1)));
        exp_pc = exp_pc + 1'b1;
        pops++;
      end
      if (redir_valid) begin
        exp_pc    = redir_tgt;
        exp_fetch = redir_tgt;
      end
      redir_prev = redir_valid;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    mem_q.delete();
    repeat (3) step();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_inst", 32'(if_inst), 32'd0);
    check_eq("rst_pc", 32'(if_pc), 32'd0);
    check_eq("rst_pc_inc", 32'(if_pc_inc), 32'd1);
    exp_pc     = RESET_PC;
    exp_fetch  = RESET_PC;
    last_due   = cyc;
    redir_prev = 1'b0;
    acks       = 0;
    pops       = 0;
    rst_v      = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    do begin
      step();
      k++;
    end while (!if_valid && k < 50);
    if (!if_valid) check_eq(tag, 32'd0, 32'd1);
  endtask

  initial begin
    int first;
    int base;

    // Sequential stream with a 1-cycle memory
    lat_min = 1; lat_max = 1; ack_pct = 100; rdy_pct = 100;
    do_reset();
    step();
    check_eq("idle_no_req", 32'(imem_req), 32'd0);
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (if_valid && first < 0) first = k;
    end
    check_eq("first_valid_lat", 32'(first), 32'd3);
    for (int k = 0; k < 8; k++) begin
      step();
      check_eq("steady_valid", 32'(if_valid), 32'd1);
    end

    // Decode stalled: queue fills to DEPTH and requests stop
    rdy_pct = 0;
    repeat (10) step();
    check_eq("credit_req_off", 32'(imem_req), 32'd0);
    check_eq("queued_words", 32'(acks - pops), 32'(DEPTH));
    check_eq("no_in_flight", 32'(mem_q.size()), 32'd0);
    rdy_pct = 100;
    repeat (8) step();

    // 2-cycle memory, redirect with two reads outstanding
    lat_min = 2; lat_max = 2;
    repeat (8) step();
    first = 0;
    while (mem_q.size() != 2 && first < 20) begin
      step();
      first++;
    end
    check_eq("two_in_flight", 32'(mem_q.size()), 32'd2);
    redir_tgt = 16'h0040;
    redir_req = 1'b1;
    step();
    wait_valid("redir40_timeout");
    check_eq("redir40_pc", 32'(if_pc), 32'h0040);
    check_eq("redir40_inst", 32'(if_inst), 32'(mem_word(16'h0040)));
    repeat (6) step();

    // Redirect coinciding with a push and a pop
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    redir_tgt   = 16'h0100;
    redir_on_pp = 1'b1;
    first = 0;
    while (redir_on_pp && first < 20) begin
      step();
      first++;
    end
    check_eq("pp_redir_taken", 32'(redir_on_pp), 32'd0);
    wait_valid("redir100_timeout");
    check_eq("redir100_pc", 32'(if_pc), 32'h0100);

    // Address wrap at the top of the PC space
    redir_tgt = 16'hFFFF;
    redir_req = 1'b1;
    step();
    wait_valid("wrap_timeout0");
    check_eq("wrap_pc_top", 32'(if_pc), 32'hFFFF);
    check_eq("wrap_pc_inc", 32'(if_pc_inc), 32'h0000);
    wait_valid("wrap_timeout1");
    check_eq("wrap_pc_zero", 32'(if_pc), 32'h0000);
    check_eq("wrap_pc_inc1", 32'(if_pc_inc), 32'h0001);

    // Halt mid-stream: outstanding reads still delivered, then resume
    lat_min = 2; lat_max = 2;
    repeat (6) step();
    halt_v = 1'b1;
    base = pops;
    repeat (12) step();
    check_eq("halt_delivered", 32'((pops - base) >= 2), 32'd1);
    check_eq("halt_mem_idle", 32'(mem_q.size()), 32'd0);
    check_eq("halt_drained", 32'(if_valid), 32'd0);
    check_eq("halt_no_req", 32'(imem_req), 32'd0);
    halt_v = 1'b0;
    base = acks;
    repeat (6) step();
    check_eq("halt_resume", 32'((acks - base) > 0), 32'd1);

    // Randomized traffic: latency, ack, ready, halt and redirects
    lat_min = 1; lat_max = 3; ack_pct = 75; rdy_pct = 70;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) < 4) halt_v = !halt_v;
      if ($urandom_range(99) < 3) begin
        redir_tgt = ($urandom_range(3) == 0) ? AW'(16'hFFFC + $urandom_range(3)) : AW'($urandom);
        redir_req = 1'b1;
      end
      step();
    end
    halt_v = 1'b0; ack_pct = 100; rdy_pct = 100;
    base = pops;
    repeat (40) step();
    check_eq("liveness", 32'((pops - base) >= 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
